// File: rtl/fetch_pkg.sv
// Shared fetch-side definitions: FSM state encoding and bundle geometry helpers.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package fetch_pkg;

  // Default number of functional units per bundle; instructionCache uses the same value.
  localparam int unsigned FETCH_NFU = 2;

  // Default bundle geometry, in bytes and in byte-offset bits.
  localparam int unsigned FETCH_BUNDLE_BYTES = FETCH_NFU * 4;
  localparam int unsigned FETCH_OFFSET_BITS  = $clog2(FETCH_BUNDLE_BYTES);

  // Bundle size in bytes for a given functional-unit count.
  function automatic int unsigned bundle_bytes(input int unsigned nfu);
    return nfu * 4;
  endfunction

  // Number of low address bits that must be zero for a bundle-aligned address.
  function automatic int unsigned offset_bits(input int unsigned nfu);
    return $clog2(nfu * 4);
  endfunction

  typedef enum logic [2:0] {
    RESET   = 3'd0,
    REQ     = 3'd1,
    WAIT    = 3'd2,
    RETRY   = 3'd3,
    DELIVER = 3'd4,
    FAULT   = 3'd5
  } fetch_state_t;

endpackage

// File: rtl/toggle_sync.sv
// Two-flop synchronizer for a level/toggle signal crossing into clk.
// Latency: 2 clk cycles from input change to output change.
// Backpressure: none; input is sampled every cycle.
module toggle_sync (
  input  logic clk,
  input  logic rstN,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture; both stages clear on reset so the toggle phase starts at 0.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: one toggle-handshake cache request per bundle, line forwarded to decode.
// Latency: doFetch toggle at edge N -> bundleValid at N+3 on a hit; bundleValid-to-bundleValid best case 5 cycles.
// Backpressure: bundleReady low holds bundle/bundlePc stable and stops new requests until accepted.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned NFU                     = FETCH_NFU,
  parameter int unsigned PHYSICAL_ADDRESS_LENGTH = 56,
  parameter logic [PHYSICAL_ADDRESS_LENGTH-1:0] RESET_PC = '0,
  parameter int unsigned RETRY_CYCLES            = 4
) (
  input  logic                               clk,
  input  logic                               rstN,
  output logic [PHYSICAL_ADDRESS_LENGTH-1:0] fetchAddress,
  output logic                               doFetch,
  input  logic                               doneFetch,
  input  logic [NFU*32-1:0]                  fetchData,
  input  logic                               fetchMiss,
  input  logic                               redirect,
  input  logic [PHYSICAL_ADDRESS_LENGTH-1:0] redirectPc,
  output logic                               bundleValid,
  input  logic                               bundleReady,
  output logic [NFU*32-1:0]                  bundle,
  output logic [PHYSICAL_ADDRESS_LENGTH-1:0] bundlePc,
  output logic                               misalignedFault,
  output logic [15:0]                        missCount
);

  localparam int unsigned AW    = PHYSICAL_ADDRESS_LENGTH;
  localparam int unsigned BW    = NFU * 32;
  localparam int unsigned OFF_W = offset_bits(NFU);
  localparam int unsigned CNT_W = (RETRY_CYCLES > 1) ? $clog2(RETRY_CYCLES) : 1;
  localparam logic [AW-1:0]    PC_STEP   = AW'(bundle_bytes(NFU));
  localparam logic [CNT_W-1:0] RETRY_END = CNT_W'(RETRY_CYCLES - 1);
  localparam logic [15:0]      MISS_MAX  = 16'hFFFF;

  fetch_state_t     state, state_nxt;
  logic [AW-1:0]    pc, pc_nxt;
  logic             discard, discard_nxt;
  logic [CNT_W-1:0] retry_cnt, retry_cnt_nxt;
  logic             do_fetch_nxt;
  logic [AW-1:0]    fetch_addr_nxt;
  logic             bundle_vld_nxt;
  logic [BW-1:0]    bundle_nxt;
  logic [AW-1:0]    bundle_pc_nxt;
  logic             fault_nxt;
  logic [15:0]      miss_cnt_nxt;

  logic done_sync;
  logic idle;
  logic accept;
  logic redirect_misaligned;

  toggle_sync u_done_sync (
    .clk  (clk),
    .rstN (rstN),
    .d    (doneFetch),
    .q    (done_sync)
  );

  // No request is in flight once the synchronized response phase matches the request phase.
  assign idle                = (done_sync == doFetch);
  assign accept              = bundleValid & bundleReady;
  assign redirect_misaligned = |redirectPc[OFF_W-1:0];

  // State, PC and all output registers update together from the next-state logic.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state           <= RESET;
      pc              <= RESET_PC;
      discard         <= 1'b0;
      retry_cnt       <= '0;
      doFetch         <= 1'b0;
      fetchAddress    <= RESET_PC;
      bundleValid     <= 1'b0;
      bundle          <= '0;
      bundlePc        <= '0;
      misalignedFault <= 1'b0;
      missCount       <= '0;
    end else begin
      state           <= state_nxt;
      pc              <= pc_nxt;
      discard         <= discard_nxt;
      retry_cnt       <= retry_cnt_nxt;
      doFetch         <= do_fetch_nxt;
      fetchAddress    <= fetch_addr_nxt;
      bundleValid     <= bundle_vld_nxt;
      bundle          <= bundle_nxt;
      bundlePc        <= bundle_pc_nxt;
      misalignedFault <= fault_nxt;
      missCount       <= miss_cnt_nxt;
    end
  end

  // Next-state and datapath: redirect overrides everything, otherwise the per-state action applies.
  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    discard_nxt    = discard;
    retry_cnt_nxt  = retry_cnt;
    do_fetch_nxt   = doFetch;
    fetch_addr_nxt = fetchAddress;
    bundle_vld_nxt = bundleValid;
    bundle_nxt     = bundle;
    bundle_pc_nxt  = bundlePc;
    fault_nxt      = misalignedFault;
    miss_cnt_nxt   = missCount;

    if (redirect) begin
      if (redirect_misaligned) begin
        // Fault parks the unit; any in-flight response is absorbed later because REQ waits for idle.
        fault_nxt      = 1'b1;
        bundle_vld_nxt = 1'b0;
        discard_nxt    = 1'b0;
        state_nxt      = FAULT;
      end else begin
        pc_nxt    = redirectPc;
        fault_nxt = 1'b0;
        if (state == WAIT) begin
          // Keep waiting so the stale response is consumed and dropped before re-requesting.
          discard_nxt = 1'b1;
          state_nxt   = WAIT;
        end else begin
          discard_nxt    = 1'b0;
          bundle_vld_nxt = 1'b0;
          state_nxt      = REQ;
        end
      end
    end else begin
      case (state)
        RESET: begin
          state_nxt = REQ;
        end

        REQ: begin
          // Only one request may be outstanding, so hold off until the previous toggle is answered.
          if (idle) begin
            do_fetch_nxt   = ~doFetch;
            fetch_addr_nxt = pc;
            state_nxt      = WAIT;
          end
        end

        WAIT: begin
          if (idle) begin
            if (discard) begin
              discard_nxt = 1'b0;
              state_nxt   = REQ;
            end else if (fetchMiss) begin
              if (missCount != MISS_MAX) begin
                miss_cnt_nxt = missCount + 16'd1;
              end
              retry_cnt_nxt = '0;
              state_nxt     = RETRY;
            end else begin
              bundle_nxt     = fetchData;
              bundle_pc_nxt  = pc;
              bundle_vld_nxt = 1'b1;
              state_nxt      = DELIVER;
            end
          end
        end

        RETRY: begin
          if (retry_cnt == RETRY_END) begin
            state_nxt = REQ;
          end else begin
            retry_cnt_nxt = retry_cnt + 1'b1;
          end
        end

        DELIVER: begin
          if (accept) begin
            pc_nxt         = pc + PC_STEP;
            bundle_vld_nxt = 1'b0;
            state_nxt      = REQ;
          end
        end

        FAULT: begin
          bundle_vld_nxt = 1'b0;
        end

        default: begin
          state_nxt = RESET;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam int AW = 56;
  localparam int BW = 64;

  typedef struct {
    logic [AW-1:0] pc;
    logic [BW-1:0] dat;
  } exp_t;

  logic          clk = 1'b0;
  logic          rstN;
  logic [AW-1:0] fetchAddress;
  logic          doFetch;
  logic          doneFetch;
  logic [BW-1:0] fetchData;
  logic          fetchMiss;
  logic          redirect;
  logic [AW-1:0] redirectPc;
  logic          bundleValid;
  logic          bundleReady;
  logic [BW-1:0] bundle;
  logic [AW-1:0] bundlePc;
  logic          misalignedFault;
  logic [15:0]   missCount;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int deliv_cnt = 0;

  exp_t          exp_q[$];
  logic [AW-1:0] req_q[$];
  int            req_cyc[$];

  logic [AW-1:0] miss_addr;
  int            miss_left;

  fetch_unit dut (
    .clk             (clk),
    .rstN            (rstN),
    .fetchAddress    (fetchAddress),
    .doFetch         (doFetch),
    .doneFetch       (doneFetch),
    .fetchData       (fetchData),
    .fetchMiss       (fetchMiss),
    .redirect        (redirect),
    .redirectPc      (redirectPc),
    .bundleValid     (bundleValid),
    .bundleReady     (bundleReady),
    .bundle          (bundle),
    .bundlePc        (bundlePc),
    .misalignedFault (misalignedFault),
    .missCount       (missCount)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [BW-1:0] data_of(input logic [AW-1:0] a);
    return 64'hA5A5_0000_0000_0001 + {8'h00, a};
  endfunction

  function automatic logic [63:0] req_at(input int i);
    if (i < req_q.size()) return {8'h00, req_q[i]};
    return '1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_redirect(input logic [AW-1:0] a);
    redirectPc = a;
    redirect   = 1'b1;
    tick();
    redirect   = 1'b0;
  endtask

  task automatic wait_empty(input string tag);
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) tick();
    check_eq(tag, exp_q.size(), 0);
  endtask

  task automatic wait_req(input string tag, input int n);
    for (int i = 0; i < 300 && req_q.size() < n; i++) tick();
    check_eq(tag, req_q.size() >= n, 1);
  endtask

  // Cache model: answers each doFetch toggle before the next edge, hit or scripted miss.
  initial begin
    logic last_do;
    last_do   = 1'b0;
    doneFetch = 1'b0;
    fetchData = '0;
    fetchMiss = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rstN) begin
        last_do   = 1'b0;
        doneFetch = 1'b0;
      end else if (doFetch !== last_do) begin
        last_do = doFetch;
        req_q.push_back(fetchAddress);
        req_cyc.push_back(cyc);
        if (miss_left > 0 && fetchAddress == miss_addr) begin
          miss_left--;
          fetchMiss = 1'b1;
          fetchData = 64'hDEAD_BEEF_DEAD_BEEF;
        end else begin
          fetchMiss = 1'b0;
          fetchData = data_of(fetchAddress);
        end
        doneFetch = ~doneFetch;
      end
    end
  end

  // Decode-side monitor: every accepted bundle must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rstN === 1'b1 && bundleValid === 1'b1 && bundleReady === 1'b1) begin
      exp_t e;
      deliv_cnt++;
      check_eq("sb_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_eq("sb_pc", bundlePc, e.pc);
        check_eq("sb_data", bundle, e.dat);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int base;
    int d0;
    int n10;
    int c10[$];

    rstN        = 1'b0;
    redirect    = 1'b0;
    redirectPc  = '0;
    bundleReady = 1'b0;
    miss_addr   = '1;
    miss_left   = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_doFetch", doFetch, 0);
    check_eq("rst_fetchAddress", fetchAddress, 0);
    check_eq("rst_bundleValid", bundleValid, 0);
    check_eq("rst_bundle", bundle, 0);
    check_eq("rst_bundlePc", bundlePc, 0);
    check_eq("rst_fault", misalignedFault, 0);
    check_eq("rst_missCount", missCount, 0);
    tick();
    rstN = 1'b1;

    // First hit at address 0 and its latency.
    exp_q.push_back('{pc: 56'h0, dat: data_of(56'h0)});
    for (int i = 0; i < 20 && doFetch == 1'b0; i++) tick();
    t0 = cyc;
    for (int i = 0; i < 20 && bundleValid == 1'b0; i++) tick();
    check_eq("hit_latency", cyc - t0, 3);
    check_eq("first_addr", req_at(0), 0);
    check_eq("first_data_lo", bundle[31:0], 32'h0000_0001);

    // Backpressure: bundle held, no new request.
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("hold_bundle", bundle, data_of(56'h0));
      check_eq("hold_pc", bundlePc, 0);
    end
    check_eq("hold_no_req", req_q.size(), 1);
    bundleReady = 1'b1;
    wait_empty("deliver0");
    wait_req("req_0x8", 2);
    check_eq("next_addr", req_at(1), 56'h8);

    // Redirect while waiting on 0x8: its response is dropped.
    d0 = deliv_cnt;
    exp_q.push_back('{pc: 56'h100, dat: data_of(56'h100)});
    do_redirect(56'h100);
    wait_empty("redirect_deliver");
    bundleReady = 1'b0;
    check_eq("redirect_addr", req_at(2), 56'h100);
    check_eq("redirect_one_bundle", deliv_cnt - d0, 1);

    // Two misses on 0x10, then a hit.
    repeat (10) tick();
    base      = req_q.size();
    d0        = deliv_cnt;
    miss_addr = 56'h10;
    miss_left = 2;
    exp_q.push_back('{pc: 56'h10, dat: data_of(56'h10)});
    do_redirect(56'h10);
    bundleReady = 1'b1;
    wait_empty("miss_deliver");
    bundleReady = 1'b0;
    repeat (3) tick();
    check_eq("miss_count", missCount, 2);
    n10 = 0;
    for (int i = base; i < req_q.size(); i++) begin
      if (req_q[i] == 56'h10) begin
        n10++;
        c10.push_back(req_cyc[i]);
      end
    end
    check_eq("miss_reqs", n10, 3);
    if (c10.size() >= 2) check_eq("retry_gap", c10[1] - c10[0], 8);
    check_eq("miss_one_bundle", deliv_cnt - d0, 1);

    // Misaligned redirect faults; aligned redirect recovers.
    repeat (10) tick();
    do_redirect(56'h104);
    tick();
    check_eq("fault_set", misalignedFault, 1);
    check_eq("fault_no_valid", bundleValid, 0);
    base = req_q.size();
    repeat (20) tick();
    check_eq("fault_no_req", req_q.size(), base);
    check_eq("fault_still_no_valid", bundleValid, 0);
    exp_q.push_back('{pc: 56'h200, dat: data_of(56'h200)});
    do_redirect(56'h200);
    check_eq("fault_clear", misalignedFault, 0);
    bundleReady = 1'b1;
    wait_empty("fault_resume");
    bundleReady = 1'b0;
    check_eq("resume_addr", req_at(base), 56'h200);

    // PC wrap at the top of the address space.
    repeat (10) tick();
    base = req_q.size();
    exp_q.push_back('{pc: 56'hFF_FFFF_FFFF_FFF8, dat: data_of(56'hFF_FFFF_FFFF_FFF8)});
    do_redirect(56'hFF_FFFF_FFFF_FFF8);
    bundleReady = 1'b1;
    wait_empty("wrap_deliver");
    bundleReady = 1'b0;
    wait_req("wrap_req", base + 2);
    check_eq("wrap_top_addr", req_at(base), 56'hFF_FFFF_FFFF_FFF8);
    check_eq("wrap_zero_addr", req_at(base + 1), 0);

    // Miss counter saturation.
    repeat (10) tick();
    force dut.missCount = 16'hFFFF;
    tick();
    release dut.missCount;
    tick();
    check_eq("sat_preset", missCount, 16'hFFFF);
    miss_addr = 56'h300;
    miss_left = 1;
    exp_q.push_back('{pc: 56'h300, dat: data_of(56'h300)});
    do_redirect(56'h300);
    bundleReady = 1'b1;
    wait_empty("sat_deliver");
    bundleReady = 1'b0;
    check_eq("sat_hold", missCount, 16'hFFFF);
    check_eq("sat_miss_used", miss_left, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch front end and initiator of the instruction-cache fetch protocol. Holds the bundle PC, issues one cache request per bundle using the toggle handshake on `doFetch`/`doneFetch`, and captures the returned `NFU*32`-bit line. It forwards that line to decode over a valid/ready interface. Handles redirects, cache-miss retry and misaligned redirect targets; sits between the branch/redirect logic and `instructionCache`.

## Interface
Parameters:
- `NFU`, 2, functional units per bundle; bundle is `NFU*32` bits, `NFU*4` bytes.
- `PHYSICAL_ADDRESS_LENGTH`, 56, PC / fetch address width.
- `RESET_PC`, 0, first fetch address after reset; must be bundle-aligned.
- `RETRY_CYCLES`, 4, idle cycles between a miss response and the re-request (≥1).

Ports (name, direction, width, meaning):
- `clk` in 1: single clock, rising edge.
- `rstN` in 1: asynchronous, active-low reset.
- `fetchAddress` out `PHYSICAL_ADDRESS_LENGTH`: request address, stable while a request is outstanding.
- `doFetch` out 1: request toggle; each transition is one request.
- `doneFetch` in 1: response toggle from the cache; each transition completes one request; 0 out of reset.
- `fetchData` in `NFU*32`: returned line, valid once `doneFetch` has toggled.
- `fetchMiss` in 1: miss flag, qualified with the same `doneFetch` transition.
- `redirect` in 1: single-cycle pulse, load new PC.
- `redirectPc` in `PHYSICAL_ADDRESS_LENGTH`: redirect target.
- `bundleValid` out 1; `bundleReady` in 1: decode handshake.
- `bundle` out `NFU*32`; `bundlePc` out `PHYSICAL_ADDRESS_LENGTH`.
- `misalignedFault` out 1: sticky, set by a misaligned redirect target.
- `missCount` out 16: saturating count of miss responses.

## Operation
- Reset values: `doFetch` 0, `fetchAddress` `RESET_PC`, `bundleValid` 0, `bundle` 0, `bundlePc` 0, `misalignedFault` 0, `missCount` 0. State is RESET.
- `doneFetch` passes through a two-flop synchronizer, reset 0. A request is outstanding while the synchronized `doneFetch` ≠ `doFetch`.
- States:
  - RESET: leave after one cycle → REQ.
  - REQ: toggle `doFetch` with `fetchAddress` = pc → WAIT.
  - WAIT: when synchronized done = `doFetch`:
    - if the discard flag is set: clear it → REQ.
    - else if `fetchMiss`: increment `missCount` (saturating at 0xFFFF) → RETRY.
    - else: capture `fetchData` into `bundle` and pc into `bundlePc`, set `bundleValid` → DELIVER.
  - RETRY: count `RETRY_CYCLES` cycles → REQ, same pc.
  - DELIVER: on `bundleValid & bundleReady`, pc += `NFU*4` modulo 2^`PHYSICAL_ADDRESS_LENGTH` and `bundleValid` clears → REQ.
  - FAULT: no requests, `bundleValid` 0.
- Redirect, in any state, with highest priority:
  - If any of `redirectPc[$clog2(NFU*4)-1:0]` ≠ 0: set `misalignedFault` → FAULT.
  - Otherwise pc ← `redirectPc` and `misalignedFault` clears.
    - From WAIT: set the discard flag and stay in WAIT; the in-flight response is dropped and never reaches decode.
    - From DELIVER, REQ, RETRY or FAULT: → REQ, `bundleValid` cleared.
- FAULT is left only by reset or an aligned redirect.
- If `redirect` and `bundleValid & bundleReady` occur in the same cycle, the transfer counts as accepted. pc takes `redirectPc`, not the increment; squashing that bundle is the responsibility of decode.
- At most one request is outstanding. `doFetch` never toggles while a request is outstanding.

## Timing
- Hit path, from `doFetch` toggle at edge N:
  - the cache toggles `doneFetch` before edge N+1;
  - the synchronizer shows it at N+2;
  - `bundleValid` rises at N+3.
- Best case `bundleValid`-to-next-`bundleValid` is 5 cycles: 1 DELIVER, 1 REQ, 3 WAIT.
- Redirect sampled at edge M in DELIVER/REQ/RETRY: new `fetchAddress` and `doFetch` toggle at M+1.
- Miss: `doFetch` re-toggles `RETRY_CYCLES`+1 cycles after the miss is seen.
- Reset asserted mid-request: all state clears immediately. The cache's pending toggle is not tracked; both sides must be reset together.
- `bundle` and `bundlePc` stay stable while `bundleValid` is high and `bundleReady` is low.

## Structure
- Package `fetch_pkg`: state enum `fetch_state_t` (RESET, REQ, WAIT, RETRY, DELIVER, FAULT), bundle-size and offset-width localparams shared with `instructionCache`.
- Sub-module `toggle_sync`: two-flop synchronizer with active-low asynchronous reset, used for `doneFetch`.
- FSM, PC register, retry counter and miss counter live in `fetch_unit`.

## Test plan
- Reset, cache model hits with data `64'hA5A5_0000_0000_0001`: first `fetchAddress` = 0; `bundleValid` 3 cycles after `doFetch` toggles; `bundlePc` 0; next request at 0x8.
- `bundleReady` held low 10 cycles: `bundle` and `bundlePc` stable, no further `doFetch` toggle; releasing it advances pc by 8.
- Miss on 0x10 twice, then hit: `missCount` = 2, three requests to 0x10, exactly one bundle delivered.
- Redirect to 0x100 while WAIT on 0x8: response for 0x8 dropped; next request is 0x100; first delivered `bundlePc` is 0x100.
- Redirect to 0x104: `misalignedFault` = 1, no toggles for 20 cycles; then redirect to 0x200: fault clears, fetch resumes at 0x200.
- PC = 2^56−8 accepted: next `fetchAddress` = 0. Also force `missCount` to 0xFFFF and apply one more miss: it stays 0xFFFF.
